// File: rtl/bno085_report_parser.sv
// SHTP input-report parser for the BNO085 sensor stream. Rotation-vector and
// calibrated-gyro reports are assembled in shadow registers, then committed atomically.
module bno085_report_parser #(
  parameter logic [7:0] REPORT_CHANNEL = 8'd3,
  parameter logic [7:0] ROTVEC_ID      = 8'h05,
  parameter logic [7:0] GAMEROT_ID     = 8'h08,
  parameter logic [7:0] GYRO_ID        = 8'h02,
  parameter logic [7:0] TSBASE_ID      = 8'hFB
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               quat_valid,
  output logic signed [15:0] quat_w,
  output logic signed [15:0] quat_x,
  output logic signed [15:0] quat_y,
  output logic signed [15:0] quat_z,
  output logic               gyro_valid,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               parse_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RPT_ID,
    S_RPT_BODY,
    S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    KIND_TS,
    KIND_GYRO,
    KIND_QUAT
  } kind_t;

  state_t             state_q, state_d;
  logic [1:0]         hdr_cnt_q, hdr_cnt_d;
  logic [7:0]         len_lsb_q, len_lsb_d;
  logic [6:0]         len_msb_q, len_msb_d;
  logic [7:0]         chan_q, chan_d;
  logic [14:0]        remain_q, remain_d;
  kind_t              kind_q, kind_d;
  logic [3:0]         last_q, last_d;
  logic [3:0]         idx_q, idx_d;
  logic signed [15:0] shadow_q [4];
  logic signed [15:0] shadow_d [4];

  logic               quat_valid_q, gyro_valid_q, parse_err_q;
  logic signed [15:0] quat_w_q, quat_x_q, quat_y_q, quat_z_q;
  logic signed [15:0] gyro_x_q, gyro_y_q, gyro_z_q;

  logic               commit_quat, commit_gyro, err_d;
  logic [14:0]        hdr_len;
  logic [1:0]         slot;

  function automatic logic signed [15:0] merge_byte(input logic signed [15:0] word,
                                                    input logic [7:0]         b,
                                                    input logic               hi);
    logic signed [15:0] r;
    r = word;
    if (hi) r[15:8] = b;
    else    r[7:0]  = b;
    return r;
  endfunction

  assign hdr_len = {len_msb_q, len_lsb_q};
  // Report bytes 4..11 map onto 16-bit field slots 0..3, two bytes per slot.
  assign slot    = idx_q[2:1] - 2'd2;

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    len_lsb_d   = len_lsb_q;
    len_msb_d   = len_msb_q;
    chan_d      = chan_q;
    remain_d    = remain_q;
    kind_d      = kind_q;
    last_d      = last_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    commit_quat = 1'b0;
    commit_gyro = 1'b0;
    err_d       = 1'b0;

    if (frame_start) begin
      // A new transaction always wins; any partial report is silently dropped.
      state_d   = S_HDR;
      hdr_cnt_d = 2'd0;
      if (byte_valid) begin
        len_lsb_d = byte_data;
        hdr_cnt_d = 2'd1;
      end
    end else begin
      if (byte_valid) begin
        case (state_q)
          S_HDR: begin
            hdr_cnt_d = hdr_cnt_q + 2'd1;
            case (hdr_cnt_q)
              2'd0: len_lsb_d = byte_data;
              2'd1: len_msb_d = byte_data[6:0];
              2'd2: chan_d    = byte_data;
              default: begin
                if (hdr_len <= 15'd4 || chan_q != REPORT_CHANNEL) begin
                  state_d = S_DRAIN;
                end else begin
                  remain_d = hdr_len - 15'd4;
                  state_d  = S_RPT_ID;
                end
              end
            endcase
          end

          S_RPT_ID: begin
            remain_d = remain_q - 15'd1;
            idx_d    = 4'd1;
            if (byte_data == TSBASE_ID) begin
              kind_d = KIND_TS;
              last_d = 4'd4;
            end else if (byte_data == GYRO_ID) begin
              kind_d = KIND_GYRO;
              last_d = 4'd9;
            end else if (byte_data == GAMEROT_ID) begin
              kind_d = KIND_QUAT;
              last_d = 4'd11;
            end else begin
              kind_d = KIND_QUAT;
              last_d = 4'd13;
            end

            if (byte_data != TSBASE_ID && byte_data != GYRO_ID &&
                byte_data != GAMEROT_ID && byte_data != ROTVEC_ID) begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end else if (remain_q == 15'd1) begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end else begin
              state_d = S_RPT_BODY;
            end
          end

          S_RPT_BODY: begin
            remain_d = remain_q - 15'd1;
            idx_d    = idx_q + 4'd1;
            if (idx_q >= 4'd4 && idx_q <= 4'd11 && kind_q != KIND_TS) begin
              shadow_d[slot] = merge_byte(shadow_q[slot], byte_data, idx_q[0]);
            end

            if (idx_q == last_q) begin
              commit_quat = (kind_q == KIND_QUAT);
              commit_gyro = (kind_q == KIND_GYRO);
              state_d     = (remain_q == 15'd1) ? S_DRAIN : S_RPT_ID;
            end else if (remain_q == 15'd1) begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end

          default: ;
        endcase
      end

      // The byte sharing a frame_end cycle is handled first, so it may still commit.
      if (frame_end && state_q != S_IDLE) begin
        if (state_d == S_RPT_BODY) err_d = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hdr_cnt_q <= 2'd0;
      len_lsb_q <= 8'd0;
      len_msb_q <= 7'd0;
      chan_q    <= 8'd0;
      remain_q  <= 15'd0;
      kind_q    <= KIND_TS;
      last_q    <= 4'd0;
      idx_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      len_lsb_q <= len_lsb_d;
      len_msb_q <= len_msb_d;
      chan_q    <= chan_d;
      remain_q  <= remain_d;
      kind_q    <= kind_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
    end
  end

  // Commit stage: shadow_d already contains the final byte of the report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
      quat_valid_q <= 1'b0;
      gyro_valid_q <= 1'b0;
      parse_err_q  <= 1'b0;
      quat_w_q     <= '0;
      quat_x_q     <= '0;
      quat_y_q     <= '0;
      quat_z_q     <= '0;
      gyro_x_q     <= '0;
      gyro_y_q     <= '0;
      gyro_z_q     <= '0;
    end else begin
      shadow_q     <= shadow_d;
      quat_valid_q <= commit_quat;
      gyro_valid_q <= commit_gyro;
      parse_err_q  <= err_d;
      if (commit_quat) begin
        quat_x_q <= shadow_d[0];
        quat_y_q <= shadow_d[1];
        quat_z_q <= shadow_d[2];
        quat_w_q <= shadow_d[3];
      end
      if (commit_gyro) begin
        gyro_x_q <= shadow_d[0];
        gyro_y_q <= shadow_d[1];
        gyro_z_q <= shadow_d[2];
      end
    end
  end

  assign quat_valid = quat_valid_q;
  assign gyro_valid = gyro_valid_q;
  assign parse_err  = parse_err_q;
  assign quat_w     = quat_w_q;
  assign quat_x     = quat_x_q;
  assign quat_y     = quat_y_q;
  assign quat_z     = quat_z_q;
  assign gyro_x     = gyro_x_q;
  assign gyro_y     = gyro_y_q;
  assign gyro_z     = gyro_z_q;

endmodule
